// File: rtl/alu_op_sequencer.sv
// Control-step sequencer: turns one ALU command into per-clock data-path strobes.
// Binary, unary and wide (HI:LO) command classes; every output is registered.
module alu_op_sequencer #(
    parameter int              NUM_REGS = 16,
    parameter int              IDX_W    = 4,
    parameter int              OP_W     = 5,
    parameter logic [OP_W-1:0] OP_NEG   = 5'b01000,
    parameter logic [OP_W-1:0] OP_NOT   = 5'b01001,
    parameter logic [OP_W-1:0] OP_MUL   = 5'b01110,
    parameter logic [OP_W-1:0] OP_DIV   = 5'b01111
) (
    input  logic                Clock,
    input  logic                clear,
    input  logic                start,
    input  logic [OP_W-1:0]     op,
    input  logic [IDX_W-1:0]    ra,
    input  logic [IDX_W-1:0]    rb,
    input  logic [IDX_W-1:0]    rc,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic                Yin,
    output logic                Zlowin,
    output logic                ZHighin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                LOin,
    output logic                HIin,
    output logic [OP_W-1:0]     alu_op,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        S_IDLE, S_T_Y, S_T_OP, S_T_WLO, S_T_WHI, S_DONE
    } state_t;

    localparam logic [IDX_W:0] NREG = (IDX_W+1)'(NUM_REGS);

    state_t              r_state, w_next;
    logic [OP_W-1:0]     r_op, w_op;
    logic [IDX_W-1:0]    r_ra, r_rb, r_rc, w_ra, w_rb, w_rc;
    logic                w_cap, w_unary, w_wide, w_reject;

    logic [NUM_REGS-1:0] r_rout, r_rin, w_rout, w_rin;
    logic                r_yin, r_zlowin, r_zhighin, r_zlowout, r_zhighout, r_loin, r_hiin;
    logic                w_yin, w_zlowin, w_zhighin, w_zlowout, w_zhighout, w_loin, w_hiin;
    logic [OP_W-1:0]     r_alu_op, w_alu_op;
    logic                r_busy, r_done, r_err, w_busy, w_done, w_err;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

    always_comb begin
        // On the capture edge the first step is decoded straight from the inputs
        // so that the first strobe appears one cycle after start is sampled.
        w_cap    = (r_state == S_IDLE) && start;
        w_op     = w_cap ? op : r_op;
        w_ra     = w_cap ? ra : r_ra;
        w_rb     = w_cap ? rb : r_rb;
        w_rc     = w_cap ? rc : r_rc;
        w_unary  = (w_op == OP_NEG) || (w_op == OP_NOT);
        w_wide   = (w_op == OP_MUL) || (w_op == OP_DIV);
        w_reject = w_cap && (({1'b0, w_ra} >= NREG) ||
                             (!w_unary && ({1'b0, w_rb} >= NREG)) ||
                             (!w_wide  && ({1'b0, w_rc} >= NREG)));

        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_cap && !w_reject) w_next = w_unary ? S_T_OP : S_T_Y;
            S_T_Y:   w_next = S_T_OP;
            S_T_OP:  w_next = S_T_WLO;
            S_T_WLO: w_next = w_wide ? S_T_WHI : S_DONE;
            S_T_WHI: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase

        w_rout     = '0;
        w_rin      = '0;
        w_yin      = 1'b0;
        w_zlowin   = 1'b0;
        w_zhighin  = 1'b0;
        w_zlowout  = 1'b0;
        w_zhighout = 1'b0;
        w_loin     = 1'b0;
        w_hiin     = 1'b0;
        w_done     = 1'b0;
        w_err      = w_reject;
        w_busy     = (w_next != S_IDLE);
        w_alu_op   = w_busy ? w_op : '0;

        // Strobes are decoded for the state being entered, then registered.
        case (w_next)
            S_T_Y: begin
                w_rout = onehot(w_ra);
                w_yin  = 1'b1;
            end
            S_T_OP: begin
                w_rout    = onehot(w_unary ? w_ra : w_rb);
                w_zlowin  = 1'b1;
                w_zhighin = w_wide;
            end
            S_T_WLO: begin
                w_zlowout = 1'b1;
                if (w_wide) w_loin = 1'b1;
                else        w_rin  = onehot(w_rc);
            end
            S_T_WHI: begin
                w_zhighout = 1'b1;
                w_hiin     = 1'b1;
            end
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!clear) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_ra       <= '0;
            r_rb       <= '0;
            r_rc       <= '0;
            r_rout     <= '0;
            r_rin      <= '0;
            r_yin      <= 1'b0;
            r_zlowin   <= 1'b0;
            r_zhighin  <= 1'b0;
            r_zlowout  <= 1'b0;
            r_zhighout <= 1'b0;
            r_loin     <= 1'b0;
            r_hiin     <= 1'b0;
            r_alu_op   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            if (w_cap) begin
                r_op <= op;
                r_ra <= ra;
                r_rb <= rb;
                r_rc <= rc;
            end
            r_rout     <= w_rout;
            r_rin      <= w_rin;
            r_yin      <= w_yin;
            r_zlowin   <= w_zlowin;
            r_zhighin  <= w_zhighin;
            r_zlowout  <= w_zlowout;
            r_zhighout <= w_zhighout;
            r_loin     <= w_loin;
            r_hiin     <= w_hiin;
            r_alu_op   <= w_alu_op;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_err      <= w_err;
        end
    end

    assign Rout     = r_rout;
    assign Rin      = r_rin;
    assign Yin      = r_yin;
    assign Zlowin   = r_zlowin;
    assign ZHighin  = r_zhighin;
    assign Zlowout  = r_zlowout;
    assign Zhighout = r_zhighout;
    assign LOin     = r_loin;
    assign HIin     = r_hiin;
    assign alu_op   = r_alu_op;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Synthesizable control-step sequencer that replaces hand-written per-instruction bench FSMs.
- Accepts one ALU command (op, ra, rb, rc) and drives the data_path one-hot register-out/in strobes, Y/Z/HI/LO strobes and ALU op code, one control step per clock.
- Supports three op classes: binary (Ra op Rb -> Rc), unary (op Ra -> Rc, no Y load) and wide (Ra op Rb -> HI:LO).
- Register-file size and op-code map are parameters.

Parameters:
NUM_REGS, 16, number of general registers; width of Rout/Rin one-hot buses (2..32)
IDX_W, 4, register index width; must satisfy 2**IDX_W >= NUM_REGS
OP_W, 5, ALU op code width
OP_NEG, 5'b01000, unary op code: negate
OP_NOT, 5'b01001, unary op code: bitwise not
OP_MUL, 5'b01110, wide op code: multiply
OP_DIV, 5'b01111, wide op code: divide

Ports:
Clock  in  1  system clock; all state changes on rising edge
clear  in  1  synchronous reset, active-low
start  in  1  command request; sampled only in IDLE
op  in  OP_W  ALU op code
ra  in  IDX_W  source register A index
rb  in  IDX_W  source register B index (ignored for unary ops)
rc  in  IDX_W  destination index (ignored for wide ops)
Rout  out  NUM_REGS  one-hot register-to-bus enable
Rin  out  NUM_REGS  one-hot bus-to-register load
Yin  out  1  load Y from bus
Zlowin  out  1  capture ALU low result
ZHighin  out  1  capture ALU high result
Zlowout  out  1  drive Zlow onto bus
Zhighout  out  1  drive Zhigh onto bus
LOin  out  1  load LO from bus
HIin  out  1  load HI from bus
alu_op  out  OP_W  op code presented to the ALU
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle reject pulse

Behaviour:
- All outputs are registered. When clear=0 at a rising edge: state=IDLE and every output is 0, including alu_op. Applies mid-command; the command is abandoned and no done is issued.
- States: IDLE, T_Y, T_OP, T_WLO, T_WHI, DONE.
- Command capture in IDLE: when start=1, op/ra/rb/rc are latched.
  - Unary = op in {OP_NEG, OP_NOT}.
  - Wide = op in {OP_MUL, OP_DIV}.
  - Everything else is binary.
- Reject rule: if any used index is >= NUM_REGS (ra always; rb for binary/wide; rc for binary/unary), the command is rejected. err=1 for the next cycle, state stays IDLE, and no strobes are issued.
- Transitions:
  - IDLE: binary/wide -> T_Y; unary -> T_OP.
  - T_Y -> T_OP.
  - T_OP -> T_WLO.
  - T_WLO: wide -> T_WHI; otherwise -> DONE.
  - T_WHI -> DONE.
  - DONE -> IDLE.
- Strobes asserted during each state; all others are 0:
  - T_Y: Rout[ra], Yin.
  - T_OP: Rout[rb] for binary/wide, Rout[ra] for unary; Zlowin; ZHighin also for wide.
  - T_WLO: Zlowout; Rin[rc] for binary/unary, LOin for wide.
  - T_WHI: Zhighout, HIin.
  - DONE: done=1.
- alu_op holds the latched op from the first non-IDLE state through DONE, and is 0 in IDLE.
- Latency, with start sampled at edge k:
  - First step at cycle k+1.
  - done at cycle k+4 for binary, k+3 for unary, k+5 for wide.
- Back-to-back: a start asserted during DONE is ignored. A start in IDLE on the cycle after DONE is accepted, giving 1 idle cycle between commands.
- start while busy is ignored; the latched command is unaffected by input changes.
- rc may equal ra or rb. The write occurs in T_WLO, after all reads, so there is no hazard.
- At most one bit of Rout and one bit of Rin is set in any cycle. Rout and Rin are never both nonzero in the same cycle.

Test Plan:
- Reset: drive clear=0 for 2 cycles with start=1 -> all outputs 0, busy=0.
- Unary negate: op=01000, ra=7, rc=1 -> cycle+1: Rout=0x0080, Zlowin=1, alu_op=01000; cycle+2: Zlowout=1, Rin=0x0002; cycle+3: done=1; Yin never asserted.
- Binary op: op=00101, ra=2, rb=3, rc=2 -> Rout=0x0004 with Yin; then Rout=0x0008 with Zlowin; then Rin=0x0004 with Zlowout; done at k+4.
- Wide multiply: op=01110, ra=4, rb=5 -> T_OP asserts Zlowin and ZHighin; then LOin with Zlowout; then HIin with Zhighout; done at k+5; Rin stays 0.
- Reject: NUM_REGS=12, ra=13 -> err=1 for one cycle, busy stays 0, no strobes. Start held high through a binary command -> exactly one command executes.
- Reset mid-command: clear=0 during T_OP of a wide op -> next cycle all outputs 0, no done, and the next start executes normally.
